lose_timeout_timer: RTL and testbench
=====================================

# lose_timeout_timer

Game-over hold timer for the Flappy Bird game-state controller. It produces the `time_out` input of the game-state FSM. While the FSM is in its lose state and drives `en_counter` high, this block counts a configurable number of seconds and then issues a single-cycle `time_out` pulse, which returns the FSM to pause. It also drives a seconds-remaining value and a blink strobe for the "game over" overlay on the VGA/score path.

## Interface

**Parameters**

- `TICK_DIV`, default 50_000_000. Number of `clk` cycles per one-second tick. Legal range is ≥ 2.
- `LOSE_SECS`, default 3. Hold duration in seconds. Legal range is 1..15.
- `CNT_W`, default `$clog2(TICK_DIV)`. Width of the prescaler.

**Ports**

- `clk` input, 1 bit. System clock.
- `rst` input, 1 bit. Reset: asynchronous, active-low. Clock: `clk`.
- `en_counter` input, 1 bit. Lose-state enable from the game-state FSM; a level signal.
- `time_out` output, 1 bit. Registered one-cycle pulse marking the end of the hold period.
- `secs_left` output, 4 bits. Registered count of seconds remaining; 0 when inactive.
- `busy` output, 1 bit. Registered; high while in COUNT.
- `blink` output, 1 bit. Registered overlay strobe (see Configuration).

## Operation

**FSM states:** IDLE, COUNT, DONE. Encoding is 2 bits; the unused code recovers to IDLE.

**IDLE**
- When `en_counter` = 1, go to COUNT.
- On that transition: prescaler ← 0, `secs_left` ← LOSE_SECS, `busy` ← 1.

**COUNT**
- When `en_counter` = 0, abort:
  - go to IDLE; prescaler ← 0, `secs_left` ← 0, `busy` ← 0;
  - no `time_out` is issued.
  - Abort has priority over a tick in the same cycle.
- Otherwise, the prescaler increments each cycle.
- When the prescaler = TICK_DIV−1, a tick occurs:
  - the prescaler wraps to 0;
  - `secs_left` decrements by 1.
- A tick while `secs_left` = 1 is the final tick:
  - `secs_left` ← 0, `time_out` ← 1, `busy` ← 0;
  - go to DONE.

**DONE**
- `time_out` ← 0, so the pulse is exactly one cycle.
- Stay in DONE while `en_counter` = 1. This prevents a second count if the FSM has not yet left lose.
- When `en_counter` = 0, go to IDLE.

**Arithmetic**
- The prescaler is unsigned, CNT_W bits. It compares against TICK_DIV−1 and never exceeds it.
- `secs_left` is unsigned, 4 bits, and never underflows below 0.

**Reset**
- Asynchronous active-low reset, including mid-count, forces:
  - state IDLE, prescaler 0;
  - `time_out` 0, `secs_left` 0, `busy` 0, `blink` 0.
- A pending pulse is lost.

## Timing

- Let edge E be the first rising edge at which `en_counter` = 1 is sampled in IDLE.
  - `busy` = 1 and `secs_left` = LOSE_SECS from E.
  - Each subsequent decrement happens every TICK_DIV edges.
- `time_out` is high for exactly the one cycle after edge E + LOSE_SECS·TICK_DIV. In that same cycle `secs_left` = 0 and `busy` = 0.
- The FSM sees `time_out` on the following edge. `en_counter` therefore falls one cycle later, and the block passes through DONE back to IDLE.
- Output latency is one cycle from the sampling edge. All outputs are registers; there are no combinational input-to-output paths.
- Re-arm: after `en_counter` falls, a new count can start on the first edge that samples `en_counter` = 1 in IDLE. The minimum gap is 1 cycle low.

## Configuration

The macro `LOSE_TIMER_BLINK_EN` controls the `blink` output.

- **Defined:** in COUNT, `blink` is registered high when the prescaler < TICK_DIV/2 (integer division) and low otherwise, giving a 1 Hz, roughly 50% duty strobe. `blink` is 0 in IDLE and DONE.
- **Undefined:** the blink comparator is not built, and `blink` equals `busy` (a steady overlay).

## Test plan

All scenarios use TICK_DIV = 4 and LOSE_SECS = 3.

1. **Nominal count.** Raise `en_counter` at edge 0 and hold it.
   - `secs_left` reads 3, 2, 1 at edges 0, 4, 8.
   - A single `time_out` pulse occurs after edge 12, with `secs_left` = 0.
   - No further pulse while `en_counter` stays high for 20 more cycles.
2. **Abort.** Drop `en_counter` at edge 6.
   - Next cycle: IDLE, `secs_left` = 0, `busy` = 0.
   - `time_out` never asserts.
   - Re-raising `en_counter` restarts the count at 3.
3. **Reset mid-count.** Pull `rst` low at edge 5, asynchronously between edges.
   - All outputs are 0 immediately.
   - After release, with `en_counter` still high, the count restarts from 3 at the first edge.
4. **FSM handshake.** Deassert `en_counter` the cycle after `time_out`.
   - DONE goes to IDLE.
   - A second lose pulse 2 cycles later produces a full fresh count of 12 cycles.
5. **Blink, macro defined.** During COUNT, `blink` = 1,1,0,0 repeating within each tick. `blink` is 0 in IDLE and DONE.
6. **Blink, macro undefined.** `blink` tracks `busy` exactly in every cycle of scenario 1.

Source files
------------

// File: rtl/lose_timeout_timer.sv
// lose_timeout_timer
// Game-over hold timer. While the game-state FSM sits in its lose state with
// en_counter high, this block counts LOSE_SECS one-second ticks (TICK_DIV clk
// cycles each). It then emits a single-cycle time_out pulse and parks in DONE
// until en_counter drops, so a slow FSM cannot trigger a second count.
// secs_left and blink feed the "game over" overlay.
//
// Build option: define LOSE_TIMER_BLINK_EN to get a ~50% duty, 1 Hz blink
// strobe during the count. Without it the blink comparator is not built, and
// blink simply mirrors busy (a steady overlay).
module lose_timeout_timer #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int LOSE_SECS = 3,
  parameter int CNT_W     = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_counter,
  output logic       time_out,
  output logic [3:0] secs_left,
  output logic       busy,
  output logic       blink
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] PRESC_ONE = CNT_W'(1);
  localparam logic [3:0]       SECS_INIT = 4'(LOSE_SECS);
`ifdef LOSE_TIMER_BLINK_EN
  // Blink is high for the first half of every one-second tick.
  localparam logic [CNT_W-1:0] BLINK_HALF = CNT_W'(TICK_DIV / 2);
`endif

  state_t           state_reg;
  logic [CNT_W-1:0] presc_reg;
  logic [CNT_W-1:0] presc_next;
  logic             tick;
`ifdef LOSE_TIMER_BLINK_EN
  logic             blink_reg;
`endif

  // The prescaler never exceeds TICK_LAST, so the increment cannot wrap
  // before the tick comparison catches it.
  assign presc_next = presc_reg + PRESC_ONE;
  assign tick       = (presc_reg == TICK_LAST);

  // Main FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      time_out  <= 1'b0;
      secs_left <= 4'd0;
      busy      <= 1'b0;
`ifdef LOSE_TIMER_BLINK_EN
      blink_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          time_out  <= 1'b0;
          presc_reg <= '0;
          if (en_counter) begin
            // Edge E: secs_left and busy are visible from this edge on.
            state_reg <= COUNT;
            secs_left <= SECS_INIT;
            busy      <= 1'b1;
`ifdef LOSE_TIMER_BLINK_EN
            blink_reg <= 1'b1;
`endif
          end else begin
            secs_left <= 4'd0;
            busy      <= 1'b0;
`ifdef LOSE_TIMER_BLINK_EN
            blink_reg <= 1'b0;
`endif
          end
        end

        COUNT: begin
          time_out <= 1'b0;
          if (!en_counter) begin
            // Abort wins over a coincident tick; no pulse is issued.
            state_reg <= IDLE;
            presc_reg <= '0;
            secs_left <= 4'd0;
            busy      <= 1'b0;
`ifdef LOSE_TIMER_BLINK_EN
            blink_reg <= 1'b0;
`endif
          end else if (tick) begin
            presc_reg <= '0;
            // "<= 1" rather than "== 1" keeps secs_left from ever wrapping.
            if (secs_left <= 4'd1) begin
              state_reg <= DONE;
              secs_left <= 4'd0;
              time_out  <= 1'b1;
              busy      <= 1'b0;
`ifdef LOSE_TIMER_BLINK_EN
              blink_reg <= 1'b0;
`endif
            end else begin
              secs_left <= secs_left - 4'd1;
`ifdef LOSE_TIMER_BLINK_EN
              // Prescaler restarts at 0, which is always in the "on" half.
              blink_reg <= 1'b1;
`endif
            end
          end else begin
            presc_reg <= presc_next;
`ifdef LOSE_TIMER_BLINK_EN
            // Judge the value the prescaler is about to hold so blink lines
            // up with it cycle for cycle.
            blink_reg <= (presc_next < BLINK_HALF);
`endif
          end
        end

        DONE: begin
          // time_out drops here, so the pulse is exactly one cycle wide.
          time_out  <= 1'b0;
          presc_reg <= '0;
          secs_left <= 4'd0;
          busy      <= 1'b0;
`ifdef LOSE_TIMER_BLINK_EN
          blink_reg <= 1'b0;
`endif
          if (!en_counter) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          // Unused encoding: fall back to a clean idle.
          state_reg <= IDLE;
          presc_reg <= '0;
          time_out  <= 1'b0;
          secs_left <= 4'd0;
          busy      <= 1'b0;
`ifdef LOSE_TIMER_BLINK_EN
          blink_reg <= 1'b0;
`endif
        end
      endcase
    end
  end

`ifdef LOSE_TIMER_BLINK_EN
  assign blink = blink_reg;
`else
  // Steady overlay: shown for exactly as long as the count is running.
  assign blink = busy;
`endif

endmodule

// File: tb/tb_lose_timeout_timer.sv
// tb_lose_timeout_timer
// Directed scoreboard bench for lose_timeout_timer (TICK_DIV=4, LOSE_SECS=3).
// The driver pushes the output expected after each clock edge. The monitor
// samples 1 time unit after every rising edge and pops/compares.
// Blink expectations follow LOSE_TIMER_BLINK_EN when it is defined for the bench.
module tb_lose_timeout_timer;

  localparam int TICK_DIV  = 4;
  localparam int LOSE_SECS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_counter = 1'b0;
  logic       time_out;
  logic [3:0] secs_left;
  logic       busy;
  logic       blink;

  lose_timeout_timer #(
    .TICK_DIV (TICK_DIV),
    .LOSE_SECS(LOSE_SECS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_counter(en_counter),
    .time_out  (time_out),
    .secs_left (secs_left),
    .busy      (busy),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       time_out;
    logic [3:0] secs_left;
    logic       busy;
    logic       blink;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got to=%0b secs=%0d busy=%0b blink=%0b, expected to=%0b secs=%0d busy=%0b blink=%0b",
               name, act.time_out, act.secs_left, act.busy, act.blink,
               exp.time_out, exp.secs_left, exp.busy, exp.blink);
    end else begin
      $display("[TB] ok   %s: to=%0b secs=%0d busy=%0b blink=%0b",
               name, act.time_out, act.secs_left, act.busy, act.blink);
    end
  endtask

  // One cycle of stimulus: en is sampled at the next rising edge, whose
  // result must equal exp.
  task automatic drive(input logic en, input obs_t exp, input string name);
    @(negedge clk);
    en_counter = en;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  // k-th edge of a count, k = 0 being edge E. Hand-derived: secs_left is
  // 3,2,1 over k = 0..3, 4..7, 8..11, and the pulse follows edge E+12.
  task automatic count_cyc(input int k, input string name);
    obs_t e;
    e = '0;
    if (k < 12) begin
      e.secs_left = 4'(3 - k / 4);
      e.busy      = 1'b1;
`ifdef LOSE_TIMER_BLINK_EN
      e.blink     = ((k % 4) < 2);
`else
      e.blink     = 1'b1;
`endif
    end else begin
      e.time_out  = 1'b1;
    end
    drive(1'b1, e, $sformatf("%s k=%0d", name, k));
  endtask

  // Cycle whose expected outputs are all zero (IDLE or DONE).
  task automatic quiet_cyc(input logic en, input string name);
    drive(en, '0, name);
  endtask

  // Monitor: pops one expectation per edge whenever one is pending.
  initial begin
    obs_t  act;
    obs_t  exp;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        act = {time_out, secs_left, busy, blink};
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        compare(nm, act, exp);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t act;
    int   budget;

    // ---- Reset ----
    #1 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    act = {time_out, secs_left, busy, blink};
    compare("reset state", act, '0);
    #2 rst = 1'b1;
    quiet_cyc(1'b0, "idle after reset");
    quiet_cyc(1'b0, "idle after reset");

    // ---- Scenario 1: nominal count ----
    for (int k = 0; k <= 12; k++) count_cyc(k, "s1 nominal");
    for (int i = 0; i < 20; i++) quiet_cyc(1'b1, "s1 DONE hold");
    quiet_cyc(1'b0, "s1 release to IDLE");

    // ---- Scenario 2: abort at edge 6, then re-arm ----
    quiet_cyc(1'b0, "s2 idle");
    for (int k = 0; k <= 5; k++) count_cyc(k, "s2 count");
    quiet_cyc(1'b0, "s2 abort at edge 6");
    for (int i = 0; i < 3; i++) quiet_cyc(1'b0, "s2 idle after abort");
    for (int k = 0; k <= 4; k++) count_cyc(k, "s2 rearm");
    quiet_cyc(1'b0, "s2 abort again");

    // ---- Scenario 3: asynchronous reset mid-count ----
    for (int k = 0; k <= 5; k++) count_cyc(k, "s3 count");
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    act = {time_out, secs_left, busy, blink};
    compare("s3 async reset immediate", act, '0);
    @(posedge clk);
    #1;
    act = {time_out, secs_left, busy, blink};
    compare("s3 held in reset with en high", act, '0);
    #2 rst = 1'b1;
    for (int k = 0; k <= 12; k++) count_cyc(k, "s3 restart");

    // ---- Scenario 4: FSM handshake and fresh second count ----
    quiet_cyc(1'b1, "s4 DONE while FSM reacts");
    quiet_cyc(1'b0, "s4 DONE to IDLE");
    quiet_cyc(1'b0, "s4 idle gap");
    for (int k = 0; k <= 12; k++) count_cyc(k, "s4 second count");
    quiet_cyc(1'b1, "s4 DONE");
    quiet_cyc(1'b0, "s4 IDLE");
    // Minimum one-cycle gap re-arm.
    for (int k = 0; k <= 1; k++) count_cyc(k, "s4 min-gap rearm");
    quiet_cyc(1'b0, "s4 final abort");

    // Drain the scoreboard within a bounded number of cycles.
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
